riscv_muldiv_unit: RTL and testbench

- Iterative RV32M/RV64M multiply/divide execution unit, parametrised in datapath width.
- Sits beside the single-cycle ALU in the execute stage and accepts ops whose funct7 is 0000001.
- Holds the pipeline through `busy` while it computes one bit per cycle, then returns the result with a one-cycle `done` pulse.
- Decodes all eight M-extension funct3 encodings, handles RISC-V divide-by-zero and signed-overflow rules, and supports pipeline flush.

---
 rtl/riscv_muldiv_unit_if.sv | 32 +++
 rtl/riscv_muldiv_unit.sv | 168 ++++++++++++++++
 tb/tb_riscv_muldiv_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/riscv_muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : riscv_muldiv_unit_if
// Description : Request/response bundle between the execute stage and the
//               iterative multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface riscv_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            flush;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    // Pipeline side: issues operations and watches for completion
    modport master (
        output start, flush, funct3, op_a, op_b,
        input  busy, done, result
    );

    // Execution unit side
    modport slave (
        input  start, flush, funct3, op_a, op_b,
        output busy, done, result
    );
endinterface
`default_nettype wire

// File: rtl/riscv_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : riscv_muldiv_unit
// Description : Iterative RV32M/RV64M multiply/divide unit. Shift-add
//               multiply and restoring divide, one bit per cycle, with
//               sign fix-up, divide-by-zero / overflow fast paths and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    riscv_muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [CW-1:0]     cnt;
    logic [2:0]        op;
    logic [XLEN-1:0]   opnd;        // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] acc;         // {hi, lo}: product, or {remainder, dividend/quotient}
    logic              neg_res;     // product / quotient must be negated
    logic              neg_rem;     // remainder must be negated
    logic [XLEN-1:0]   result_q;

    logic              accept;
    logic              signed_a;
    logic              signed_b;
    logic              sign_a;
    logic              sign_b;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              div_zero;
    logic              div_ovf;
    logic              fast;
    logic [XLEN-1:0]   fast_result;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_result;

    // Operand decode: signedness, magnitudes and fast-path detection
    always_comb begin
        accept   = bus.start && (state == S_IDLE || state == S_DONE);
        signed_a = 1'b0;
        signed_b = 1'b0;
        case (bus.funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                signed_a = 1'b1;
                signed_b = 1'b1;
            end
            3'b010: signed_a = 1'b1;
            default: ;
        endcase
        sign_a   = signed_a & bus.op_a[XLEN-1];
        sign_b   = signed_b & bus.op_b[XLEN-1];
        mag_a    = sign_a ? (~bus.op_a + 1'b1) : bus.op_a;
        mag_b    = sign_b ? (~bus.op_b + 1'b1) : bus.op_b;
        div_zero = bus.funct3[2] && (bus.op_b == '0);
        div_ovf  = bus.funct3[2] && !bus.funct3[0]
                   && (bus.op_a == {1'b1, {(XLEN-1){1'b0}}})
                   && (bus.op_b == '1);
        fast     = div_zero || div_ovf;
        if (div_zero)
            fast_result = bus.funct3[1] ? bus.op_a : '1;
        else
            fast_result = bus.funct3[1] ? '0 : bus.op_a;
    end

    // One iteration of shift-add multiply and restoring divide
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (!div_diff[XLEN])
            div_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else
            div_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end

    // Sign fix-up and result selection from the raw unsigned result
    always_comb begin
        prod_fix = neg_res ? (~acc + 1'b1) : acc;
        quo_fix  = neg_res ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
        rem_fix  = neg_rem ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
        if (op[2])
            fix_result = op[1] ? rem_fix : quo_fix;
        else if (op[1:0] == 2'b00)
            fix_result = prod_fix[XLEN-1:0];
        else
            fix_result = prod_fix[2*XLEN-1:XLEN];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; flush overrides everything including a new start
    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (bus.start) state_nxt = fast ? S_DONE : S_CALC;
                S_CALC: if (cnt == CW'(1)) state_nxt = S_FIX;
                S_FIX:  state_nxt = S_DONE;
                S_DONE: state_nxt = bus.start ? (fast ? S_DONE : S_CALC) : S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Status outputs decoded from state
    always_comb begin
        bus.busy = (state == S_CALC) || (state == S_FIX);
        bus.done = (state == S_DONE);
    end

    assign bus.result = result_q;

    // Datapath: latch operands on accept, iterate in CALC, commit in FIX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            op       <= '0;
            opnd     <= '0;
            acc      <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            result_q <= '0;
        end else if (!bus.flush) begin
            if (accept) begin
                op      <= bus.funct3;
                neg_res <= sign_a ^ sign_b;
                neg_rem <= sign_a;
                opnd    <= bus.funct3[2] ? mag_b : mag_a;
                acc     <= {{XLEN{1'b0}}, (bus.funct3[2] ? mag_a : mag_b)};
                cnt     <= CW'(XLEN);
                if (fast)
                    result_q <= fast_result;
            end else if (state == S_CALC) begin
                acc <= op[2] ? div_next : mul_next;
                cnt <= cnt - 1'b1;
            end else if (state == S_FIX) begin
                result_q <= fix_result;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_riscv_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_muldiv_unit
// Description : Directed self-checking bench for riscv_muldiv_unit with a
//               32-bit and an 8-bit instance and result scoreboards.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_muldiv_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] q32[$];
    logic [7:0]  q8[$];

    riscv_muldiv_unit_if #(.XLEN(32)) bus32();
    riscv_muldiv_unit_if #(.XLEN(8))  bus8();

    riscv_muldiv_unit #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    riscv_muldiv_unit #(.XLEN(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

    initial forever #5 clk = ~clk;

    // Scoreboard for the 32-bit unit: every done pops one expected result
    always @(negedge clk) begin
        if (rst_n && bus32.done === 1'b1) begin
            checks++;
            assert (q32.size() != 0) else begin
                errors++;
                $error("FAIL done32_unexpected: got done with %0d pending, required >0", q32.size());
            end
            if (q32.size() != 0) begin
                logic [31:0] e;
                e = q32.pop_front();
                checks++;
                assert (bus32.result === e) else begin
                    errors++;
                    $error("FAIL result32: got %08h required %08h", bus32.result, e);
                end
            end
        end
    end

    // Scoreboard for the 8-bit unit
    always @(negedge clk) begin
        if (rst_n && bus8.done === 1'b1) begin
            checks++;
            assert (q8.size() != 0) else begin
                errors++;
                $error("FAIL done8_unexpected: got done with %0d pending, required >0", q8.size());
            end
            if (q8.size() != 0) begin
                logic [7:0] e;
                e = q8.pop_front();
                checks++;
                assert (bus8.result === e) else begin
                    errors++;
                    $error("FAIL result8: got %02h required %02h", bus8.result, e);
                end
            end
        end
    end

    // Issue one 32-bit op at the current negedge and follow it to done.
    // Returns in the done cycle with start low. hold keeps start asserted
    // with scrambled operands during the first CALC cycles.
    task automatic run32(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input bit hold);
        int cyc;
        bus32.start  = 1'b1;
        bus32.funct3 = f3;
        bus32.op_a   = a;
        bus32.op_b   = b;
        q32.push_back(exp);
        @(negedge clk);
        cyc = 1;
        while (bus32.done !== 1'b1 && cyc < 100) begin
            bus32.start  = hold && (cyc < 6);
            bus32.funct3 = 3'($urandom_range(0, 7));
            bus32.op_a   = $urandom();
            bus32.op_b   = $urandom();
            checks++;
            assert (bus32.busy === 1'b1) else begin
                errors++;
                $error("FAIL busy32_calc: got %b required 1 at cycle %0d", bus32.busy, cyc);
            end
            @(negedge clk);
            cyc++;
        end
        bus32.start = 1'b0;
        checks++;
        assert (cyc == lat) else begin
            errors++;
            $error("FAIL latency32 f3=%0d: got %0d required %0d", f3, cyc, lat);
        end
        checks++;
        assert (bus32.busy === 1'b0) else begin
            errors++;
            $error("FAIL busy32_done: got %b required 0", bus32.busy);
        end
    endtask

    task automatic run8(input logic [2:0] f3, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp, input int lat);
        int cyc;
        bus8.start  = 1'b1;
        bus8.funct3 = f3;
        bus8.op_a   = a;
        bus8.op_b   = b;
        q8.push_back(exp);
        @(negedge clk);
        bus8.start = 1'b0;
        cyc = 1;
        while (bus8.done !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        assert (cyc == lat) else begin
            errors++;
            $error("FAIL latency8 f3=%0d: got %0d required %0d", f3, cyc, lat);
        end
    endtask

    initial begin
        bus32.start = 1'b0; bus32.flush = 1'b0; bus32.funct3 = '0; bus32.op_a = '0; bus32.op_b = '0;
        bus8.start  = 1'b0; bus8.flush  = 1'b0; bus8.funct3  = '0; bus8.op_a  = '0; bus8.op_b  = '0;

        // Reset state
        #12;
        checks++; assert (bus32.busy === 1'b0) else begin errors++; $error("FAIL rst_busy32: got %b required 0", bus32.busy); end
        checks++; assert (bus32.done === 1'b0) else begin errors++; $error("FAIL rst_done32: got %b required 0", bus32.done); end
        checks++; assert (bus32.result === 32'h0) else begin errors++; $error("FAIL rst_result32: got %08h required 0", bus32.result); end
        checks++; assert (bus8.result === 8'h0) else begin errors++; $error("FAIL rst_result8: got %02h required 0", bus8.result); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // Multiplies
        run32(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, 1'b0);
        @(negedge clk);
        run32(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34, 1'b0);
        run32(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 1'b0);
        run32(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 1'b0);
        @(negedge clk);

        // Divides, back to back
        run32(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 1'b0);
        run32(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 1'b0);
        run32(3'b101, 32'd100,      32'd7,        32'd14,       34, 1'b0);
        run32(3'b111, 32'd100,      32'd7,        32'd2,        34, 1'b0);
        run32(3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34, 1'b0);
        run32(3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        34, 1'b0);
        @(negedge clk);

        // Fast paths: divide by zero and signed overflow
        run32(3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 1'b0);
        run32(3'b110, 32'd5,        32'd0,        32'd5,        1, 1'b0);
        run32(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1'b0);
        run32(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1, 1'b0);
        @(negedge clk);

        // start held during CALC is ignored
        run32(3'b000, 32'd5,        32'd6,        32'd30,       34, 1'b1);
        @(negedge clk);

        // Flush at edge 10 of a DIV
        bus32.start = 1'b1; bus32.funct3 = 3'b100; bus32.op_a = 32'd1000; bus32.op_b = 32'd3;
        @(negedge clk);
        bus32.start = 1'b0;
        for (int i = 1; i < 10; i++) @(negedge clk);
        bus32.flush = 1'b1;
        @(negedge clk);
        bus32.flush = 1'b0;
        checks++; assert (bus32.busy === 1'b0) else begin errors++; $error("FAIL flush_busy: got %b required 0", bus32.busy); end
        checks++; assert (bus32.done === 1'b0) else begin errors++; $error("FAIL flush_done: got %b required 0", bus32.done); end
        checks++; assert (bus32.result === 32'd30) else begin errors++; $error("FAIL flush_result: got %08h required %08h", bus32.result, 32'd30); end
        for (int i = 0; i < 30; i++) @(negedge clk);
        run32(3'b000, 32'd3,        32'd4,        32'd12,       34, 1'b0);
        @(negedge clk);

        // Asynchronous reset mid-CALC
        bus32.start = 1'b1; bus32.funct3 = 3'b101; bus32.op_a = 32'd100; bus32.op_b = 32'd7;
        @(negedge clk);
        bus32.start = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; assert (bus32.busy === 1'b0) else begin errors++; $error("FAIL arst_busy: got %b required 0", bus32.busy); end
        checks++; assert (bus32.done === 1'b0) else begin errors++; $error("FAIL arst_done: got %b required 0", bus32.done); end
        checks++; assert (bus32.result === 32'h0) else begin errors++; $error("FAIL arst_result: got %08h required 0", bus32.result); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        run32(3'b000, 32'd3,        32'd4,        32'd12,       34, 1'b0);
        @(negedge clk);

        // XLEN=8 instance
        run8(3'b000, 8'h0F, 8'h11, 8'hFF, 10);
        @(negedge clk);
        run8(3'b100, 8'h80, 8'hFF, 8'h80, 1);
        @(negedge clk);
        run8(3'b101, 8'd200, 8'd7, 8'd28, 10);
        @(negedge clk);
        run8(3'b110, 8'hF9, 8'd2, 8'hFF, 10);
        @(negedge clk);
        @(negedge clk);

        checks++;
        assert (q32.size() == 0 && q8.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: got %0d/%0d pending required 0/0", q32.size(), q8.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
